// File: rtl/uart_pkg.sv
// Shared UART definitions: the baud generator state and default rate constants.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_DIV = 54;
  localparam int unsigned UART_OSR         = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } baud_state_e;

endpackage

// File: rtl/frac_acc.sv
// Fractional divisor accumulator; carry stretches the following oversample period by one cycle.
module frac_acc #(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clr_i) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (step_i) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign carry_o = carry_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable UART baud tick generator (oversample, mid-bit and bit ticks).
// Define BAUD_FRAC_EN to build the fractional divisor accumulator.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W       = 21,
  parameter int unsigned OSR         = UART_OSR,
  parameter int unsigned FRAC_W      = 4,
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic              div_load_i,
  input  logic [CNT_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              os_tick_o,
  output logic              mid_tick_o,
  output logic              bit_tick_o,
  output logic              div_err_o,
  output logic              busy_o
);

  localparam int unsigned OS_W = $clog2(OSR);

  baud_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shd_div_q, shd_div_d;
  logic [CNT_W-1:0] last_c;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             pend_q, pend_d;
  logic             os_q, os_d, mid_q, mid_d, bit_q, bit_d;
  logic             err_q, err_d, busy_q, busy_d;
  logic             load_ok_c, apply_new_c, apply_shd_c, shadow_wr_c;
  logic             acc_clr_c, acc_step_c, carry_c;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_d, shd_frac_q, shd_frac_d;

  frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr_i   (acc_clr_c),
    .step_i  (acc_step_c),
    .frac_i  (frac_q),
    .carry_o (carry_c)
  );

  always_comb begin
    frac_d     = apply_new_c ? frac_i : (apply_shd_c ? shd_frac_q : frac_q);
    shd_frac_d = shadow_wr_c ? frac_i : shd_frac_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      frac_q     <= '0;
      shd_frac_q <= '0;
    end else begin
      frac_q     <= frac_d;
      shd_frac_q <= shd_frac_d;
    end
  end
`else
  logic unused_frac;
  assign carry_c     = 1'b0;
  assign unused_frac = ^{frac_i, acc_clr_c, acc_step_c};
`endif

  assign load_ok_c = div_load_i && (div_i >= CNT_W'(2));
  assign last_c    = div_q - CNT_W'(1) + CNT_W'(carry_c);

  // Next-state, counters, tick flags and divisor shadow handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    os_cnt_d    = os_cnt_q;
    os_d        = 1'b0;
    mid_d       = 1'b0;
    bit_d       = 1'b0;
    busy_d      = 1'b0;
    err_d       = div_load_i && !load_ok_c;
    apply_new_c = 1'b0;
    apply_shd_c = 1'b0;
    shadow_wr_c = 1'b0;
    acc_clr_c   = 1'b0;
    acc_step_c  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        os_cnt_d    = '0;
        acc_clr_c   = 1'b1;
        apply_new_c = load_ok_c;
        apply_shd_c = pend_q;
        if (en_i) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d     = IDLE;
          cnt_d       = '0;
          os_cnt_d    = '0;
          acc_clr_c   = 1'b1;
          shadow_wr_c = load_ok_c;
        end else begin
          busy_d = 1'b1;
          if (restart_i) begin
            cnt_d       = '0;
            os_cnt_d    = '0;
            acc_clr_c   = 1'b1;
            apply_new_c = load_ok_c;
          end else if (cnt_q == last_c) begin
            os_d        = 1'b1;
            mid_d       = (os_cnt_q == OS_W'(OSR/2 - 1));
            bit_d       = (os_cnt_q == OS_W'(OSR - 1));
            os_cnt_d    = bit_d ? '0 : os_cnt_q + OS_W'(1);
            cnt_d       = '0;
            acc_step_c  = 1'b1;
            apply_new_c = load_ok_c;
            apply_shd_c = pend_q;
          end else begin
            cnt_d       = cnt_q + CNT_W'(1);
            shadow_wr_c = load_ok_c;
          end
        end
      end
    endcase

    // A direct load always beats an older shadowed one
    div_d     = apply_new_c ? div_i : (apply_shd_c ? shd_div_q : div_q);
    shd_div_d = shadow_wr_c ? div_i : shd_div_q;
    if (shadow_wr_c)
      pend_d = 1'b1;
    else if (apply_new_c || apply_shd_c)
      pend_d = 1'b0;
    else
      pend_d = pend_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      os_cnt_q  <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      shd_div_q <= '0;
      pend_q    <= 1'b0;
      os_q      <= 1'b0;
      mid_q     <= 1'b0;
      bit_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      os_cnt_q  <= os_cnt_d;
      div_q     <= div_d;
      shd_div_q <= shd_div_d;
      pend_q    <= pend_d;
      os_q      <= os_d;
      mid_q     <= mid_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign os_tick_o  = os_q;
  assign mid_tick_o = mid_q;
  assign bit_tick_o = bit_q;
  assign div_err_o  = err_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: vector table, directed corner sequences and random traffic vs a deadline-based model.
module tb_baud_tick_gen;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned OSR    = 4;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned DEF    = 4;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, en, rs, ld;
  logic [CNT_W-1:0] div;
  logic [3:0]       frac;
  logic             os_tick_o, mid_tick_o, bit_tick_o, div_err_o, busy_o;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .CNT_W(CNT_W), .OSR(OSR), .FRAC_W(FRAC_W), .DEFAULT_DIV(DEF)
  ) dut (
    .clk_in     (clk),
    .rst        (rst),
    .en_i       (en),
    .restart_i  (rs),
    .div_load_i (ld),
    .div_i      (div),
    .frac_i     (frac),
    .os_tick_o  (os_tick_o),
    .mid_tick_o (mid_tick_o),
    .bit_tick_o (bit_tick_o),
    .div_err_o  (div_err_o),
    .busy_o     (busy_o)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int ticks[$];
  int bits[$];

  // Model: absolute tick deadlines, tick number since phase zero, integer fraction accumulator.
  bit m_run, m_pend;
  int m_next, m_t, m_div, m_frac, m_shd, m_shdf, m_acc, m_carry;
  bit e_os, e_mid, e_bit, e_err, e_busy;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
  endtask

  task automatic model(input bit r, input bit e, input bit s, input bit l, input int d, input int f);
    bit ok;
    ok    = l && (d >= 2);
    e_os  = 1'b0;
    e_mid = 1'b0;
    e_bit = 1'b0;
    e_err = l && (d < 2);
    if (r) begin
      m_run = 1'b0; m_pend = 1'b0; m_div = DEF; m_frac = 0;
      m_acc = 0; m_carry = 0; e_err = 1'b0; e_busy = 1'b0;
      return;
    end
    if (!m_run) begin
      if (ok) begin m_div = d; m_frac = f; end
      else if (m_pend) begin m_div = m_shd; m_frac = m_shdf; end
      m_pend = 1'b0;
      if (e) begin
        m_run = 1'b1; m_t = 0; m_acc = 0; m_carry = 0; m_next = cyc + m_div;
      end
      e_busy = e;
    end else if (!e) begin
      m_run  = 1'b0;
      e_busy = 1'b0;
      if (ok) begin m_shd = d; m_shdf = f; m_pend = 1'b1; end
    end else begin
      e_busy = 1'b1;
      if (s) begin
        if (ok) begin m_div = d; m_frac = f; m_pend = 1'b0; end
        m_t = 0; m_acc = 0; m_carry = 0; m_next = cyc + m_div;
      end else if (cyc == m_next) begin
        e_os  = 1'b1;
        e_mid = (m_t % OSR) == (OSR/2 - 1);
        e_bit = (m_t % OSR) == (OSR - 1);
        m_t++;
        m_acc   = m_acc + m_frac;
        m_carry = FRAC_ON ? m_acc / 16 : 0;
        m_acc   = m_acc % 16;
        if (ok) begin m_div = d; m_frac = f; end
        else if (m_pend) begin m_div = m_shd; m_frac = m_shdf; end
        m_pend = 1'b0;
        m_next = cyc + m_div + m_carry;
      end else if (ok) begin
        m_shd = d; m_shdf = f; m_pend = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic l,
                      input logic [CNT_W-1:0] d, input logic [3:0] f);
    rst = r; en = e; rs = s; ld = l; div = d; frac = f;
    @(posedge clk);
    cyc++;
    model(r, e, s, l, int'(d), int'(f));
    #1;
    check("os_tick",  int'(os_tick_o),  int'(e_os));
    check("mid_tick", int'(mid_tick_o), int'(e_mid));
    check("bit_tick", int'(bit_tick_o), int'(e_bit));
    check("div_err",  int'(div_err_o),  int'(e_err));
    check("busy",     int'(busy_o),     int'(e_busy));
    if (os_tick_o === 1'b1) ticks.push_back(cyc);
    if (bit_tick_o === 1'b1) bits.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
  endtask

  function automatic int tk(input int i);
    if (i < ticks.size()) return ticks[i];
    return -1000;
  endfunction

  function automatic int bk(input int i);
    if (i < bits.size()) return bits[i];
    return -1000;
  endfunction

  typedef struct {
    logic r, e, s, l;
    logic [CNT_W-1:0] d;
    logic [3:0] f;
    logic os, mid, bt, err, busy;
  } vec_t;

  vec_t vecs[18];
  int   t0;

  initial begin
    for (int i = 0; i < 18; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(DEF), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[0]     = '{1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(DEF), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5].os  = 1'b1;
    vecs[9].os  = 1'b1;  vecs[9].mid = 1'b1;
    vecs[10].l  = 1'b1;  vecs[10].d  = CNT_W'(1); vecs[10].err = 1'b1;
    vecs[13].os = 1'b1;
    vecs[17].os = 1'b1;  vecs[17].bt = 1'b1;

    // Reset, default divisor 4, OSR 4, rejected load of 1
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].l, vecs[i].d, vecs[i].f);
      check($sformatf("tbl%0d_os", i),   int'(os_tick_o),  int'(vecs[i].os));
      check($sformatf("tbl%0d_mid", i),  int'(mid_tick_o), int'(vecs[i].mid));
      check($sformatf("tbl%0d_bit", i),  int'(bit_tick_o), int'(vecs[i].bt));
      check($sformatf("tbl%0d_err", i),  int'(div_err_o),  int'(vecs[i].err));
      check($sformatf("tbl%0d_busy", i), int'(busy_o),     int'(vecs[i].busy));
    end

    // Load mid-period: current period stays 4, then 6
    step(1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    ticks.delete();
    step(1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    t0 = cyc;
    run(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, CNT_W'(6), 4'd0);
    run(20);
    check("load_first", tk(0) - t0, 4);
    check("load_p1", tk(1) - tk(0), 6);
    check("load_p2", tk(2) - tk(1), 6);

    // Restart at cnt 2
    step(1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    ticks.delete(); bits.delete();
    run(3);
    step(1'b0, 1'b1, 1'b1, 1'b0, CNT_W'(DEF), 4'd0);
    t0 = cyc;
    run(20);
    check("restart_tick", tk(0) - t0, 4);
    check("restart_bit", bk(0) - t0, 16);

    // Enable dropped mid-bit for 10 cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    run(7);
    ticks.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
      if (i == 0) check("drop_busy", int'(busy_o), 0);
    end
    check("drop_noticks", ticks.size(), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    t0 = cyc;
    run(8);
    check("reentry_tick", tk(0) - t0, 4);

    // Reset in RUN discards a pending load
    step(1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    run(2);
    step(1'b0, 1'b1, 1'b0, 1'b1, CNT_W'(6), 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    check("rst_outs", int'({os_tick_o, mid_tick_o, bit_tick_o, div_err_o, busy_o}), 0);
    ticks.delete();
    step(1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    t0 = cyc;
    run(12);
    check("rst_p0", tk(0) - t0, 4);
    check("rst_p1", tk(1) - tk(0), 4);

`ifdef BAUD_FRAC_EN
    // div 4, frac 8: periods 4,4,5,4,5 and 4.5 on average
    step(1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(4), 4'd8);
    ticks.delete();
    step(1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    t0 = cyc;
    run(460);
    check("frac_p0", tk(0) - t0, 4);
    check("frac_p1", tk(1) - tk(0), 4);
    check("frac_p2", tk(2) - tk(1), 5);
    check("frac_p3", tk(3) - tk(2), 4);
    check("frac_p4", tk(4) - tk(3), 5);
    check("frac_avg100", tk(100) - tk(0), 450);
`endif

    // Random traffic against the model
    step(1'b1, 1'b0, 1'b0, 1'b0, CNT_W'(DEF), 4'd0);
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 19) != 0),
           1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 19) == 0),
           CNT_W'($urandom_range(0, 9)),
           4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
